ssd_scan_ctrl: RTL

Parametrised N-digit seven-segment scan controller that replaces the fixed two-digit hex mux in the game top level. It holds a shadow copy of the display word and applies it only at frame boundaries, so digits never tear. It inserts an all-off dead time between digits to suppress ghosting. It supports per-digit enable, per-digit decimal points and leading-zero blanking. All outputs are active-low and drive the board anodes and cathodes directly.

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/ssd_hex_decoder.sv | 15 +
 rtl/ssd_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared definitions for the seven-segment scan controller:
//   - ssd_state_e : scan FSM states (SHOW, BLANK)
//   - SEG_BLANK   : all-off cathode pattern (active-low)
//   - SEG_TABLE   : hex digit -> {a..g} cathode pattern, active-low
package ssd_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } ssd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder
// Combinational hex nibble to seven-segment cathode decoder.
// Ports:
//   nib_i   [3:0]  hex nibble
//   seg_n_o [6:0]  cathodes {a..g}, active-low
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
// N-digit multiplexed seven-segment scan controller. The displayed word is
// shadowed: loads go into a pending register which is copied to the active
// register only at a frame boundary, so a frame never mixes old and new
// digits. Each digit is followed by an all-off dead time to suppress ghosting.
// Ports:
//   board_clk, Reset    clock, asynchronous active-high reset
//   value_in            hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in               decimal point request per digit, active-high
//   digit_en            per-digit enable (live, not shadowed)
//   load                strobe capturing value_in/dp_in into pending register
//   lz_blank_en         leading-zero blanking enable (live)
//   an_n, seg_n, dp_n   anodes / cathodes / dp, active-low, registered
//   digit_idx           digit slot currently on the outputs
//   frame_tick          one-cycle pulse when digit 0 of a new frame appears
//   pending             a loaded value waits for the next frame boundary
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter  int NUM_DIGITS   = 8,
  parameter  int SCAN_CYCLES  = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int MAXC  = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  ssd_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      advance, wrap;

  logic [4*NUM_DIGITS-1:0]   act_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]     act_dp_q, pend_dp_q;
  logic                      pend_q;
  logic                      boundary_q;

  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [IDX_W-1:0]          idx_out_q;
  logic                      tick_q;

  logic [3:0]                nib;
  logic [6:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     lz_dark;
  logic                      zero_above;
  logic                      dark;

  // Scan FSM: state register
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Scan FSM: next state. With no dead time, SHOW chains straight into the
  // next digit's SHOW and BLANK is never entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    advance = 1'b0;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) advance = 1'b1;
          else                   state_d = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          advance = 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
    wrap  = advance && (idx_q == IDX_LAST);
    idx_d = idx_q;
    if (advance) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
  end

  // Shadow registers: the frame boundary transfers the pending value before
  // a coincident load overwrites it, so that load waits one more frame.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      boundary_q <= 1'b0;
    end else begin
      boundary_q <= wrap;
      if (wrap && pend_q) begin
        act_val_q <= pend_val_q;
        act_dp_q  <= pend_dp_q;
        pend_q    <= 1'b0;
      end
      if (load) begin
        pend_val_q <= value_in;
        pend_dp_q  <= dp_in;
        pend_q     <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (act_val_q[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above;
    end
  end

  assign nib  = act_val_q[4*idx_q +: 4];
  assign dark = !digit_en[idx_q] || (lz_blank_en && lz_dark[idx_q]);

  ssd_hex_decoder u_dec (
    .nib_i   (nib),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == SHOW && !dark) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dec_seg;
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  // Output register stage: everything the board sees is one cycle behind the
  // scan state; frame_tick is delayed once more to line up with digit 0.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      idx_out_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      idx_out_q <= idx_q;
      tick_q    <= boundary_q;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign digit_idx  = idx_out_q;
  assign frame_tick = tick_q;
  assign pending    = pend_q;

endmodule
